value_recognizer: RTL and testbench

VALUE_RECOGNIZER -- requirements
Module: value_recognizer

---
 rtl/value_recognizer_if.sv | 26 ++
 rtl/value_recognizer.sv | 103 ++++++++++
 tb/tb_value_recognizer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/value_recognizer_if.sv
// Signal bundle for value_recognizer: control, pattern inputs and recognition outputs.
// The master side drives pattern and control; the slave side is the recognizer.
interface value_recognizer_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             enable;
  logic [WIDTH-1:0] value_in;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] mask;
  logic             clear_count;
  logic             match;
  logic             match_pulse;
  logic [CNT_W-1:0] match_count;
  logic             count_sat;

  modport master (
    output enable, value_in, target, mask, clear_count,
    input  match, match_pulse, match_count, count_sat
  );

  modport slave (
    input  enable, value_in, target, mask, clear_count,
    output match, match_pulse, match_count, count_sat
  );
endinterface

// File: rtl/value_recognizer.sv
// Masked pattern recognizer: asserts match after HOLD_CYCLES consecutive hits,
// strobes match_pulse on each new recognition and keeps a saturating event count.
module value_recognizer #(
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  value_recognizer_if.slave bus
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    MATCHED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             pulse_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q;
  logic             hit;
  logic             go;
  logic             enter;

  // Target and mask are never latched, so a change takes effect on the very next edge.
  assign hit = ((bus.value_in ^ bus.target) & bus.mask) == '0;
  assign go  = bus.enable && hit;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (go) begin
          if (HOLD_CYCLES == 1) begin
            state_d = MATCHED;
          end else begin
            state_d = QUALIFY;
            hold_d  = HW'(1);
          end
        end
      end
      QUALIFY: begin
        if (!go) begin
          state_d = IDLE;
          hold_d  = '0;
        end else if (hold_q == HW'(HOLD_CYCLES - 1)) begin
          state_d = MATCHED;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      MATCHED: begin
        if (!go) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
      end
    endcase
  end

  assign enter = (state_d == MATCHED) && (state_q != MATCHED);

  // Clear beats a coincident increment; the count holds at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.clear_count)     cnt_d = '0;
    else if (enter && !sat_q) cnt_d = cnt_q + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      pulse_q <= enter;
      cnt_q   <= cnt_d;
      sat_q   <= &cnt_d;
    end
  end

  assign bus.match       = (state_q == MATCHED);
  assign bus.match_pulse = pulse_q;
  assign bus.match_count = cnt_q;
  assign bus.count_sat   = sat_q;

endmodule

// File: tb/tb_value_recognizer.sv
// Directed self-checking bench for value_recognizer: defaults, a 2-bit counter
// variant and a HOLD_CYCLES=1 variant share one clock and reset.
module tb_value_recognizer;

  logic clk = 1'b0;
  logic reset;
  int   vectors    = 0;
  int   miscompares = 0;
  int   pulses;

  always #5 clk = ~clk;

  value_recognizer_if #(.WIDTH(4), .CNT_W(8)) b0 ();
  value_recognizer_if #(.WIDTH(4), .CNT_W(2)) b1 ();
  value_recognizer_if #(.WIDTH(4), .CNT_W(8)) b2 ();

  value_recognizer #(.WIDTH(4), .HOLD_CYCLES(4), .CNT_W(8)) d0 (.clk(clk), .reset(reset), .bus(b0.slave));
  value_recognizer #(.WIDTH(4), .HOLD_CYCLES(4), .CNT_W(2)) d1 (.clk(clk), .reset(reset), .bus(b1.slave));
  value_recognizer #(.WIDTH(4), .HOLD_CYCLES(1), .CNT_W(8)) d2 (.clk(clk), .reset(reset), .bus(b2.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge and settle; outputs then reflect that edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk0(input string tag, input logic m, input logic p, input int c, input logic s);
    check({tag, ".match"}, 32'(b0.match), 32'(m));
    check({tag, ".pulse"}, 32'(b0.match_pulse), 32'(p));
    check({tag, ".count"}, 32'(b0.match_count), 32'(c));
    check({tag, ".sat"}, 32'(b0.count_sat), 32'(s));
  endtask

  initial begin
    reset = 1'b1;
    b0.enable = 1'b1; b0.value_in = 4'h0; b0.target = 4'h6; b0.mask = 4'hF; b0.clear_count = 1'b0;
    b1.enable = 1'b0; b1.value_in = 4'h0; b1.target = 4'h6; b1.mask = 4'hF; b1.clear_count = 1'b0;
    b2.enable = 1'b0; b2.value_in = 4'h0; b2.target = 4'h6; b2.mask = 4'hF; b2.clear_count = 1'b0;
    tick(); tick();
    chk0("reset", 1'b0, 1'b0, 0, 1'b0);
    check("reset.d1_count", 32'(b1.match_count), 0);
    check("reset.d2_match", 32'(b2.match), 0);
    reset = 1'b0;

    // Sweep: the 4th sample of value 6 starts match, which lasts through the window.
    pulses = 0;
    for (int v = 0; v < 16; v++) begin
      for (int c = 1; c <= 6; c++) begin
        b0.value_in = 4'(v);
        tick();
        check($sformatf("sweep.v%0d.c%0d.match", v, c), 32'(b0.match), 32'(v == 6 && c >= 4));
        check($sformatf("sweep.v%0d.c%0d.pulse", v, c), 32'(b0.match_pulse), 32'(v == 6 && c == 4));
        pulses += int'(b0.match_pulse);
      end
    end
    check("sweep.pulses", 32'(pulses), 1);
    check("sweep.count", 32'(b0.match_count), 1);
    check("sweep.sat", 32'(b0.count_sat), 0);

    // Clear while idle.
    b0.value_in = 4'h0; b0.clear_count = 1'b1; tick(); b0.clear_count = 1'b0;
    chk0("clear", 1'b0, 1'b0, 0, 1'b0);

    // Run of 3, one-cycle gap, run of 4.
    b0.value_in = 4'h6;
    for (int c = 1; c <= 3; c++) begin
      tick(); check($sformatf("gap.run1.c%0d", c), 32'(b0.match), 0);
    end
    b0.value_in = 4'h7; tick(); check("gap.miss", 32'(b0.match), 0);
    b0.value_in = 4'h6;
    for (int c = 1; c <= 4; c++) begin
      tick(); check($sformatf("gap.run2.c%0d", c), 32'(b0.match), 32'(c == 4));
    end
    chk0("gap.end", 1'b1, 1'b1, 1, 1'b0);

    // Partial mask: bits 3 and 0 are don't-care.
    b0.value_in = 4'h0; b0.clear_count = 1'b1; tick(); b0.clear_count = 1'b0;
    b0.mask = 4'b0110;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      logic [3:0] vals [4];
      vals = '{4'h6, 4'h7, 4'hE, 4'hF};
      for (int c = 1; c <= 5; c++) begin
        b0.value_in = vals[k];
        tick();
        check($sformatf("mask.k%0d.c%0d", k, c), 32'(b0.match), 32'(c >= 4));
        pulses += int'(b0.match_pulse);
      end
      b0.value_in = 4'h0; tick(); check($sformatf("mask.k%0d.sep", k), 32'(b0.match), 0);
    end
    check("mask.pulses", 32'(pulses), 4);
    check("mask.count", 32'(b0.match_count), 4);

    // Target change while matched drops match on the next edge.
    b0.mask = 4'hF; b0.value_in = 4'h6;
    tick(); tick(); tick(); tick();
    chk0("tgt.matched", 1'b1, 1'b1, 5, 1'b0);
    b0.target = 4'h5; tick();
    check("tgt.dropped", 32'(b0.match), 0);
    b0.target = 4'h6;

    // Reset while matched.
    tick(); tick(); tick(); tick();
    chk0("rstm.pre", 1'b1, 1'b1, 6, 1'b0);
    reset = 1'b1; tick(); reset = 1'b0;
    chk0("rstm.post", 1'b0, 1'b0, 0, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      tick(); check($sformatf("rstm.req.c%0d", c), 32'(b0.match), 32'(c == 4));
    end
    check("rstm.count", 32'(b0.match_count), 1);

    // Reset while qualifying with hold_cnt=2: qualification must start over.
    b0.value_in = 4'h0; tick();
    b0.value_in = 4'h6; tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk0("rstq.post", 1'b0, 1'b0, 0, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      tick(); check($sformatf("rstq.req.c%0d", c), 32'(b0.match), 32'(c == 4));
    end

    // enable low with hit held never matches.
    b0.value_in = 4'h0; tick();
    b0.enable = 1'b0; b0.value_in = 4'h6;
    for (int c = 1; c <= 8; c++) begin
      tick(); check($sformatf("dis.c%0d", c), 32'(b0.match), 0);
    end
    check("dis.count", 32'(b0.match_count), 1);

    // clear_count mid-qualify leaves the FSM untouched.
    b0.enable = 1'b1;
    tick(); tick();
    b0.clear_count = 1'b1; tick(); b0.clear_count = 1'b0;
    check("clrq.match", 32'(b0.match), 0);
    check("clrq.count", 32'(b0.match_count), 0);
    tick();
    chk0("clrq.end", 1'b1, 1'b1, 1, 1'b0);

    // 2-bit counter saturation; clear wins over the 5th entry.
    b1.enable = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      b1.value_in = 4'h6;
      tick(); tick(); tick();
      if (k == 5) b1.clear_count = 1'b1;
      tick();
      b1.clear_count = 1'b0;
      check($sformatf("sat.e%0d.pulse", k), 32'(b1.match_pulse), 1);
      check($sformatf("sat.e%0d.count", k), 32'(b1.match_count), (k == 5) ? 0 : ((k < 3) ? k : 3));
      check($sformatf("sat.e%0d.sat", k), 32'(b1.count_sat), 32'(k >= 3 && k < 5));
      b1.value_in = 4'h0; tick();
    end

    // HOLD_CYCLES=1: match the cycle after the first hit.
    b2.enable = 1'b1; b2.value_in = 4'h6; tick();
    check("h1.match", 32'(b2.match), 1);
    check("h1.pulse", 32'(b2.match_pulse), 1);
    check("h1.count", 32'(b2.match_count), 1);
    tick();
    check("h1.held_pulse", 32'(b2.match_pulse), 0);
    check("h1.held_match", 32'(b2.match), 1);
    b2.value_in = 4'h0; tick();
    check("h1.drop", 32'(b2.match), 0);
    b2.value_in = 4'h6; tick();
    check("h1.again_pulse", 32'(b2.match_pulse), 1);
    check("h1.again_count", 32'(b2.match_count), 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
